// File: rtl/matmul_compute.sv
// matmul_compute: single-MAC C = A*B stage fed by input_mems read ports,
// streaming C row-major on an AXI-stream master.
module matmul_compute #(
    parameter int INW  = 12,
    parameter int OUTW = 28,
    parameter int M    = 7,
    parameter int N    = 9,
    parameter int MAXK = 8,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int A_ADDR_BITS = $clog2(M * MAXK),
    localparam int B_ADDR_BITS = $clog2(MAXK * N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          matrices_loaded,
    input  logic [K_BITS-1:0]             K,
    output logic [A_ADDR_BITS-1:0]        A_read_addr,
    input  logic signed [INW-1:0]         A_data,
    output logic [B_ADDR_BITS-1:0]        B_read_addr,
    input  logic signed [INW-1:0]         B_data,
    output logic                          compute_finished,
    output logic signed [OUTW-1:0]        AXIS_TDATA,
    output logic                          AXIS_TVALID,
    input  logic                          AXIS_TREADY,
    output logic                          AXIS_TLAST
);

    localparam int I_BITS = $clog2(M + 1);
    localparam int J_BITS = $clog2(N + 1);
    localparam int PW     = 2 * INW;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        OUT,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_n;
    logic [K_BITS-1:0]        kreg;
    logic [K_BITS-1:0]        k;
    logic [I_BITS-1:0]        i;
    logic [J_BITS-1:0]        j;
    logic [A_ADDR_BITS-1:0]   a_base;
    logic [A_ADDR_BITS-1:0]   a_addr;
    logic [B_ADDR_BITS-1:0]   b_addr;
    logic signed [OUTW-1:0]   acc;
    logic                     acc_en;
    logic signed [PW-1:0]     prod;
    logic                     hs;
    logic                     last_el;
    logic                     last_k;
    logic                     last_j;

    assign prod    = PW'(A_data) * PW'(B_data);
    assign hs      = (state == OUT) && AXIS_TREADY;
    assign last_j  = (j == J_BITS'(N - 1));
    assign last_el = (i == I_BITS'(M - 1)) && last_j;
    assign last_k  = (k == kreg - K_BITS'(1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (matrices_loaded)
                    state_n = (K == '0) ? OUT : ISSUE;
            end
            ISSUE: begin
                if (last_k)
                    state_n = DRAIN;
            end
            DRAIN: state_n = OUT;
            OUT: begin
                if (hs) begin
                    if (last_el)
                        state_n = DONE;
                    else if (kreg != '0)
                        state_n = ISSUE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kreg   <= '0;
            k      <= '0;
            i      <= '0;
            j      <= '0;
            a_base <= '0;
            a_addr <= '0;
            b_addr <= '0;
            acc    <= '0;
            acc_en <= 1'b0;
        end else begin
            // read data lands one cycle after its ISSUE, including the DRAIN cycle
            acc_en <= (state == ISSUE);
            unique case (state)
                IDLE: begin
                    if (matrices_loaded) begin
                        kreg   <= K;
                        k      <= '0;
                        i      <= '0;
                        j      <= '0;
                        a_base <= '0;
                        a_addr <= '0;
                        b_addr <= '0;
                        acc    <= '0;
                    end
                end
                ISSUE: begin
                    k <= k + K_BITS'(1);
                    if (!last_k) begin
                        a_addr <= a_addr + A_ADDR_BITS'(1);
                        b_addr <= b_addr + B_ADDR_BITS'(N);
                    end
                end
                OUT: begin
                    if (hs) begin
                        acc <= '0;
                        k   <= '0;
                        if (last_j) begin
                            j      <= '0;
                            i      <= i + I_BITS'(1);
                            a_base <= a_base + A_ADDR_BITS'(kreg);
                            a_addr <= a_base + A_ADDR_BITS'(kreg);
                            b_addr <= '0;
                        end else begin
                            j      <= j + J_BITS'(1);
                            a_addr <= a_base;
                            b_addr <= B_ADDR_BITS'(j) + B_ADDR_BITS'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (acc_en)
                acc <= acc + OUTW'(prod);
        end
    end

    assign A_read_addr      = a_addr;
    assign B_read_addr      = b_addr;
    assign AXIS_TVALID      = (state == OUT);
    assign AXIS_TDATA       = (state == OUT) ? acc : '0;
    assign AXIS_TLAST       = (state == OUT) && last_el;
    assign compute_finished = (state == DONE);

endmodule
